// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel coordinates, registered sync/enable decodes,
// and a ce-qualified delay line that keeps pad outputs aligned with registered overlays.
module vga_sync_gen #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_DELAY  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on_d,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    // {display_on, hsync, vsync} as held by an empty delay stage
    localparam logic [2:0] PIPE_RST = {1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE};

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       h_wrap;
    logic       f_wrap;

    always_comb begin
        x_next = x;
        y_next = y;
        h_wrap = (x == H_LAST);
        f_wrap = h_wrap && (y == V_LAST);
        if (ce) begin
            x_next = h_wrap ? 10'd0 : x + 10'd1;
            if (h_wrap) begin
                y_next = f_wrap ? 10'd0 : y + 10'd1;
            end
        end
    end

    // Decodes are taken from x_next/y_next so they land in the same cycle as the coordinates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= 10'd0;
            y           <= 10'd0;
            frame_count <= 8'd0;
            display_on  <= 1'b1;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            x           <= x_next;
            y           <= y_next;
            display_on  <= (x_next < H_VIS) && (y_next < V_VIS);
            hsync       <= ((x_next >= HS_START) && (x_next < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= ((y_next >= VS_START) && (y_next < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            line_start  <= h_wrap;
            frame_start <= f_wrap;
            if (f_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_bypass
            assign display_on_d = display_on;
            assign hsync_d      = hsync;
            assign vsync_d      = vsync;
        end else begin : g_pipe
            logic [2:0] pipe [PIPE_DELAY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        pipe[i] <= PIPE_RST;
                    end
                end else if (ce) begin
                    pipe[0] <= {display_on, hsync, vsync};
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign display_on_d = pipe[PIPE_DELAY-1][2];
            assign hsync_d      = pipe[PIPE_DELAY-1][1];
            assign vsync_d      = pipe[PIPE_DELAY-1][0];
        end
    endgenerate

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two instances (default horizontal timing with PIPE_DELAY=1, and a
// tiny raster with PIPE_DELAY=0) checked every cycle against a pixel-count arithmetic model.
module tb_vga_sync_gen;

  // Instance A: 800-pixel lines, shortened frame so a frame wrap fits in the run
  localparam int AHD = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVD = 20,  AVF = 2,  AVS = 2,  AVB = 3;
  localparam int AHT = AHD + AHF + AHS + AHB;
  localparam int AVT = AVD + AVF + AVS + AVB;
  // Instance B: tiny raster, active-high sync, no delay
  localparam int BHD = 8, BHF = 2, BHS = 3, BHB = 2;
  localparam int BVD = 4, BVF = 1, BVS = 2, BVB = 1;
  localparam int BHT = BHD + BHF + BHS + BHB;
  localparam int BVT = BVD + BVF + BVS + BVB;

  logic clk, rst, ce;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_disp, a_hs, a_vs, a_disp_d, a_hs_d, a_vs_d, a_ls, a_fs;
  logic       b_disp, b_hs, b_vs, b_disp_d, b_hs_d, b_vs_d, b_ls, b_fs;
  logic [7:0] a_fc, b_fc;

  int checks = 0;
  int failures = 0;

  vga_sync_gen #(
    .H_DISPLAY(AHD), .H_FRONT(AHF), .H_SYNC(AHS), .H_BACK(AHB),
    .V_DISPLAY(AVD), .V_FRONT(AVF), .V_SYNC(AVS), .V_BACK(AVB),
    .SYNC_ACTIVE(1'b0), .PIPE_DELAY(1)
  ) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .x(a_x), .y(a_y),
    .display_on(a_disp), .hsync(a_hs), .vsync(a_vs),
    .display_on_d(a_disp_d), .hsync_d(a_hs_d), .vsync_d(a_vs_d),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_sync_gen #(
    .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
    .SYNC_ACTIVE(1'b1), .PIPE_DELAY(0)
  ) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .x(b_x), .y(b_y),
    .display_on(b_disp), .hsync(b_hs), .vsync(b_vs),
    .display_on_d(b_disp_d), .hsync_d(b_hs_d), .vsync_d(b_vs_d),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model state: pixels advanced since reset, and whether the last edge had ce
  int unsigned n;
  logic        pulse;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n     <= 0;
      pulse <= 1'b0;
    end else begin
      pulse <= ce;
      if (ce) n <= n + 1;
    end
  end

  // {x, y, display_on, hsync, vsync} of pixel number p in a raster
  function automatic logic [22:0] raster(int unsigned p, int hd, int hf, int hs, int hb,
                                         int vd, int vf, int vs, int vb, logic sa);
    int ht, vt, px, py;
    logic d, h, v;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    px = int'(p % ht);
    py = int'((p / ht) % vt);
    d = (px < hd) && (py < vd);
    h = (px >= hd + hf && px < hd + hf + hs) ? sa : ~sa;
    v = (py >= vd + vf && py < vd + vf + vs) ? sa : ~sa;
    return {10'(px), 10'(py), d, h, v};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: every negedge, both instances against the model
  always @(negedge clk) begin
    logic [22:0] ea, eb, ea_d;
    ea = raster(n, AHD, AHF, AHS, AHB, AVD, AVF, AVS, AVB, 1'b0);
    eb = raster(n, BHD, BHF, BHS, BHB, BVD, BVF, BVS, BVB, 1'b1);
    ea_d = (n >= 1) ? raster(n - 1, AHD, AHF, AHS, AHB, AVD, AVF, AVS, AVB, 1'b0)
                    : {20'd0, 1'b0, 1'b1, 1'b1};
    chk("a_x", a_x, ea[22:13]);
    chk("a_y", a_y, ea[12:3]);
    chk("a_disp", a_disp, ea[2]);
    chk("a_hsync", a_hs, ea[1]);
    chk("a_vsync", a_vs, ea[0]);
    chk("a_disp_d", a_disp_d, ea_d[2]);
    chk("a_hsync_d", a_hs_d, ea_d[1]);
    chk("a_vsync_d", a_vs_d, ea_d[0]);
    chk("a_line_start", a_ls, pulse && (n % AHT == 0));
    chk("a_frame_start", a_fs, pulse && (n % (AHT * AVT) == 0));
    chk("a_frame_count", a_fc, (n / (AHT * AVT)) % 256);
    chk("b_x", b_x, eb[22:13]);
    chk("b_y", b_y, eb[12:3]);
    chk("b_disp", b_disp, eb[2]);
    chk("b_hsync", b_hs, eb[1]);
    chk("b_vsync", b_vs, eb[0]);
    chk("b_disp_d", b_disp_d, eb[2]);
    chk("b_hsync_d", b_hs_d, eb[1]);
    chk("b_vsync_d", b_vs_d, eb[0]);
    chk("b_line_start", b_ls, pulse && (n % BHT == 0));
    chk("b_frame_start", b_fs, pulse && (n % (BHT * BVT) == 0));
    chk("b_frame_count", b_fc, (n / (BHT * BVT)) % 256);
  end

  // driver: advance k ce-qualified pixels, leaving us 1 time unit after the last edge
  task automatic run(input int k);
    ce = 1'b1;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic clk_step(input logic c);
    ce = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    ce  = 1'b0;
    #1;
    chk("rst_x", a_x, 0);
    chk("rst_disp", a_disp, 1);
    chk("rst_hsync", a_hs, 1);
    chk("rst_disp_d", a_disp_d, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // random ce until A sits at x=300, y=10
    guard = 0;
    while (n != 10 * AHT + 300 && guard < 20000) begin
      clk_step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      guard++;
    end
    chk("reach_mid_line", int'(n), 10 * AHT + 300);
    chk("mid_x", a_x, 300);
    chk("mid_y", a_y, 10);
    chk("mid_disp_d", a_disp_d, 1);

    // asynchronous reset with no clock edge in between
    ce  = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_x", a_x, 0);
    chk("async_y", a_y, 0);
    chk("async_fc", a_fc, 0);
    chk("async_disp", a_disp, 1);
    chk("async_hsync", a_hs, 1);
    chk("async_vsync", a_vs, 1);
    chk("async_disp_d", a_disp_d, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ce every clk: horizontal window, line wrap and frame wrap
    run(640);
    chk("x640", a_x, 640);
    chk("x640_disp", a_disp, 0);
    chk("x640_hsync", a_hs, 1);
    run(16);
    chk("x656_hsync", a_hs, 0);
    chk("x656_hsync_d", a_hs_d, 1);
    run(1);
    chk("x657_hsync_d", a_hs_d, 0);
    run(95);
    chk("x752", a_x, 752);
    chk("x752_hsync", a_hs, 1);
    run(6 * AHT - 1 - 752);
    chk("pre_wrap_x", a_x, 799);
    chk("pre_wrap_y", a_y, 5);
    run(1);
    chk("wrap_x", a_x, 0);
    chk("wrap_y", a_y, 6);
    chk("wrap_ls", a_ls, 1);
    chk("wrap_fs", a_fs, 0);
    run(1);
    chk("wrap_ls_drop", a_ls, 0);
    run(AHT * AVT - 1 - int'(n));
    chk("pre_frame_x", a_x, 799);
    chk("pre_frame_y", a_y, AVT - 1);
    chk("pre_frame_fc", a_fc, 0);
    run(1);
    chk("frame_x", a_x, 0);
    chk("frame_y", a_y, 0);
    chk("frame_fc", a_fc, 1);
    chk("frame_fs", a_fs, 1);
    chk("frame_ls", a_ls, 1);

    // ce every other clk, then random ce
    for (int i = 0; i < 2000; i++) clk_step(i[0]);
    for (int i = 0; i < 2000; i++) clk_step(1'(($urandom >> 3) & 1));

    // B reaches its 256th frame wrap
    run(256 * BHT * BVT - 1 - int'(n));
    chk("b_fc255", b_fc, 255);
    run(1);
    chk("b_fc_wrap", b_fc, 0);
    chk("b_fs_wrap", b_fs, 1);
    chk("b_x_wrap", b_x, 0);
    ce = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA raster timing: pixel coordinates, sync pulses, and a display-enable signal. It drives the `x`/`y` buses consumed by the text and sprite overlay blocks. It also emits pipeline-delayed copies of the sync and enable signals, so pad outputs stay aligned with overlays that register their result one or more pixel cycles after sampling `x`/`y`.

## Interface
Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of hsync/vsync while asserted
- PIPE_DELAY, 1, pixel cycles of delay on the `*_d` outputs; legal range 0..4

Ports:
- clk  in  1  system clock; pixel clock or an integer multiple of it
- rst  in  1  asynchronous reset, active-high
- ce  in  1  pixel enable; counters advance only on clk edges where ce=1
- x  out  10  current pixel column, 0..H_TOTAL-1
- y  out  10  current line, 0..V_TOTAL-1
- display_on  out  1  high when x<H_DISPLAY and y<V_DISPLAY
- hsync  out  1  horizontal sync, aligned with x/y
- vsync  out  1  vertical sync, aligned with x/y
- display_on_d  out  1  display_on delayed by PIPE_DELAY pixel cycles
- hsync_d  out  1  hsync delayed by PIPE_DELAY pixel cycles
- vsync_d  out  1  vsync delayed by PIPE_DELAY pixel cycles
- line_start  out  1  one-clk pulse on horizontal wrap
- frame_start  out  1  one-clk pulse on frame wrap
- frame_count  out  8  frame counter, wraps at 256

## Operation
- Derived constants: H_TOTAL = sum of the H_* parameters (800 by default); V_TOTAL = sum of the V_* parameters (525 by default).
- On a clk edge with ce=1:
  - x increments.
  - At x=H_TOTAL-1, x wraps to 0 and y increments.
  - At x=H_TOTAL-1 and y=V_TOTAL-1, both x and y wrap to 0 and frame_count increments modulo 256.
- ce=0: every register holds its value; line_start and frame_start are 0.
- Decodes are registered from the next-state counter values, so they are valid in the same cycle as the x/y they describe. No combinational path runs from x/y to the outputs.
- hsync = SYNC_ACTIVE when H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (x=656..751 by default); otherwise ~SYNC_ACTIVE.
- vsync = SYNC_ACTIVE when V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (y=490..491 by default); otherwise ~SYNC_ACTIVE.
- line_start = 1 for exactly the clk in which x has just become 0 through a wrap.
- frame_start = 1 for exactly the clk in which (x,y) has just become (0,0) through a wrap. line_start is also 1 in that cycle.
- Delay line:
  - PIPE_DELAY-deep shift register holding {display_on, hsync, vsync}.
  - Shifts only when ce=1, so the delay is in pixel cycles, not clk cycles.
  - PIPE_DELAY=0 bypasses it: each `*_d` output equals its undelayed source.
- All counter arithmetic is unsigned. Counters never hold a value ≥ its total.

## Timing
- Reset values, applied immediately and asynchronously:
  - x=0, y=0, frame_count=0.
  - display_on=1, hsync=vsync=~SYNC_ACTIVE.
  - line_start=frame_start=0.
  - All delay stages: display_on=0, hsync=vsync=~SYNC_ACTIVE.
- The first ce=1 edge after reset release moves x to 1. No line_start or frame_start pulse is produced at reset.
- Reset asserted mid-frame returns every output to its reset value at once; no partial-line state survives.
- Latency:
  - x/y and their decodes: 0 pixel cycles relative to each other.
  - `*_d` outputs: exactly PIPE_DELAY ce-qualified cycles behind their source.
- After reset release, `*_d` outputs show their reset values until PIPE_DELAY ce cycles have elapsed.
- Line period = H_TOTAL ce cycles. Frame period = H_TOTAL*V_TOTAL ce cycles (420000 by default).

## Test plan
- Reset: assert rst mid-line at x=300, y=100 → x=0, y=0, frame_count=0, display_on=1, hsync=vsync=1, display_on_d=0, all within the same cycle, with no clk edge required.
- hsync window, ce=1 every clk → hsync falls to 0 when x=656 and rises to 1 when x=752. display_on falls when x=640.
- Line wrap → x steps 799→0, y steps 5→6, line_start=1 for one clk, frame_start stays 0.
- Frame wrap → (799,524)→(0,0), frame_count 0→1, frame_start=1 and line_start=1 in the same clk. vsync is 0 only for y=490..491.
- ce toggling (ce=1 every other clk), PIPE_DELAY=1 → x advances once per two clks. hsync_d equals the previous pixel's hsync; hsync_d falls at the ce edge where x moves 656→657.
- PIPE_DELAY=0 → display_on_d, hsync_d, vsync_d equal their sources every cycle. frame_count wraps 255→0 after 256 frames.
